// File: rtl/gpu_mem_pkg.sv
// Shared types and sizing helpers for the GPU memory channel arbiter.
// The arbitration policy is selected by MEM_ARB_ROUND_ROBIN_EN in mem_channel_arbiter.
package gpu_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } mem_arb_state_t;

    localparam int DEF_NUM_CHANNELS = 4;
    localparam int DEF_ADDR_BITS    = 8;
    localparam int DEF_DATA_BITS    = 8;

    // A one-channel index would be zero bits wide; keep at least one bit.
    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_rr_picker.sv
// Combinational N-way picker: first requester at or after start_ptr, wrapping.
// Used with start_ptr tied to 0 when MEM_ARB_ROUND_ROBIN_EN is not defined.
module mem_rr_picker
    import gpu_mem_pkg::*;
#(
    parameter int NUM_CHANNELS = DEF_NUM_CHANNELS,
    parameter int IDX_W        = idx_bits(NUM_CHANNELS)
) (
    input  logic [NUM_CHANNELS-1:0] req_i,
    input  logic [IDX_W-1:0]        start_ptr_i,
    output logic [NUM_CHANNELS-1:0] grant_o,
    output logic [IDX_W-1:0]        grant_idx_o
);

    logic        found;
    int unsigned cand;

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        cand        = 0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            cand = (int'(start_ptr_i) + i) % NUM_CHANNELS;
            if (!found && req_i[cand]) begin
                found         = 1'b1;
                grant_o[cand] = 1'b1;
                grant_idx_o   = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/mem_channel_arbiter.sv
// Serialises per-channel LSU requests onto one memory port, one transaction in flight.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin; otherwise lowest index wins.
module mem_channel_arbiter
    import gpu_mem_pkg::*;
#(
    parameter int NUM_CHANNELS = DEF_NUM_CHANNELS,
    parameter int ADDR_BITS    = DEF_ADDR_BITS,
    parameter int DATA_BITS    = DEF_DATA_BITS
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_CHANNELS-1:0]           req_en,
    input  logic [NUM_CHANNELS-1:0]           req_wr,
    input  logic [NUM_CHANNELS*ADDR_BITS-1:0] req_addr,
    input  logic [NUM_CHANNELS*DATA_BITS-1:0] req_wdata,
    output logic [NUM_CHANNELS-1:0]           rsp_valid,
    output logic [DATA_BITS-1:0]              rsp_rdata,
    output logic                              mem_valid,
    output logic                              mem_wr,
    output logic [ADDR_BITS-1:0]              mem_addr,
    output logic [DATA_BITS-1:0]              mem_wdata,
    input  logic                              mem_ready,
    input  logic                              mem_rsp_valid,
    input  logic [DATA_BITS-1:0]              mem_rdata,
    output logic                              busy
);

    localparam int IDX_W = idx_bits(NUM_CHANNELS);

    mem_arb_state_t       state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 wr_q, wr_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [DATA_BITS-1:0] wdata_q, wdata_d;
    logic [DATA_BITS-1:0] rdata_q, rdata_d;

    logic [NUM_CHANNELS-1:0] grant;
    logic [IDX_W-1:0]        grant_idx;
    logic [IDX_W-1:0]        start_ptr;
    logic                    req_any;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (state_q == IDLE && req_any) begin
            ptr_d = (grant_idx == IDX_W'(NUM_CHANNELS - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

    assign start_ptr = ptr_q;
`else
    assign start_ptr = '0;
`endif

    mem_rr_picker #(
        .NUM_CHANNELS(NUM_CHANNELS),
        .IDX_W       (IDX_W)
    ) u_picker (
        .req_i      (req_en),
        .start_ptr_i(start_ptr),
        .grant_o    (grant),
        .grant_idx_o(grant_idx)
    );

    assign req_any = |grant;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (req_any) begin
                    state_d = ISSUE;
                    idx_d   = grant_idx;
                    wr_d    = req_wr[grant_idx];
                    addr_d  = req_addr[grant_idx*ADDR_BITS +: ADDR_BITS];
                    wdata_d = req_wdata[grant_idx*DATA_BITS +: DATA_BITS];
                    // Cleared here so a write completion reports zero data.
                    rdata_d = '0;
                end
            end
            ISSUE: begin
                if (mem_ready) state_d = wr_q ? RESP : WAIT;
            end
            WAIT: begin
                if (mem_rsp_valid) begin
                    rdata_d = mem_rdata;
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        rsp_valid = '0;
        if (state_q == RESP) rsp_valid[idx_q] = 1'b1;
    end

    assign rsp_rdata = (state_q == RESP) ? rdata_q : '0;
    assign mem_valid = (state_q == ISSUE);
    assign mem_wr    = wr_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = (state_q != IDLE);

endmodule
